layout_engine: RTL

Parametrised layout and dispatch stage between the element parser and the pixel renderers. Consumes a handshaked stream of parsed HTML events (characters, tag opens, attributes, closes) and keeps a cursor and a nesting stack of DIV boxes. Issues one draw job at a time to the rectangle renderer or the character renderer, with optional word wrap inside the current box. It is the next generation of the parser-side control path: it adds nesting depth, per-box clipping edges, overflow reporting and back-pressure.

---
 rtl/layout_engine.sv | 395 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/layout_engine.sv
// layout_engine: lays out parsed HTML events and dispatches draw jobs.
// Define LAYOUT_WRAP_EN to wrap overflowing glyphs onto the next line.
module layout_engine #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = 3,
  parameter int STACK_DEPTH = 4,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int FONT_W      = 5,
  parameter int FONT_H      = 7,
  parameter int KERN        = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [2:0]         ev_kind,
  input  logic [1:0]         ev_tag,
  input  logic [3:0]         ev_attr,
  input  logic [7:0]         ev_value,
  output logic               txt_start,
  output logic [X_W-1:0]     txt_x,
  output logic [Y_W-1:0]     txt_y,
  output logic [7:0]         txt_size,
  output logic [COLOR_W-1:0] txt_color,
  output logic [7:0]         txt_char,
  input  logic               txt_done,
  output logic               rect_start,
  output logic [X_W-1:0]     rect_x,
  output logic [Y_W-1:0]     rect_y,
  output logic [X_W-1:0]     rect_w,
  output logic [Y_W-1:0]     rect_h,
  output logic [COLOR_W-1:0] rect_bg,
  output logic               rect_border_en,
  output logic [COLOR_W-1:0] rect_border_color,
  input  logic               rect_done,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam logic [2:0] K_CHAR  = 3'd0;
  localparam logic [2:0] K_OPEN  = 3'd1;
  localparam logic [2:0] K_ATTR  = 3'd2;
  localparam logic [2:0] K_OEND  = 3'd3;
  localparam logic [2:0] K_CLOSE = 3'd4;

  localparam logic [1:0] TAG_DIV = 2'd1;

  localparam logic [3:0] ATT_COLOR   = 4'd0;
  localparam logic [3:0] ATT_SIZE    = 4'd1;
  localparam logic [3:0] ATT_WIDTH   = 4'd2;
  localparam logic [3:0] ATT_HEIGHT  = 4'd3;
  localparam logic [3:0] ATT_MARGIN  = 4'd4;
  localparam logic [3:0] ATT_PADDING = 4'd5;
  localparam logic [3:0] ATT_BG      = 4'd6;
  localparam logic [3:0] ATT_BORDER  = 4'd7;

  localparam int IW    = 16;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int GH_W  = $clog2(256);

  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAW_RECT,
    S_DRAW_TEXT
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]     left;
    logic [X_W-1:0]     right;
    logic [COLOR_W-1:0] color;
    logic [7:0]         size;
    logic [Y_W-1:0]     bottom;
  } frame_t;

  function automatic logic [X_W-1:0] clamp_x(
    input logic [IW-1:0] v
  );
    if (v > IW'(SCREEN_W)) return X_W'(SCREEN_W);
    return v[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(
    input logic [IW-1:0] v
  );
    if (v > IW'(SCREEN_H)) return Y_W'(SCREEN_H);
    return v[Y_W-1:0];
  endfunction

  state_t state, state_next;

  logic [X_W-1:0]     left, right, cur_x;
  logic [Y_W-1:0]     cur_y;
  logic [COLOR_W-1:0] color;
  logic [7:0]         size;

  logic [1:0]         tag_q;
  logic [7:0]         pend_width, pend_height;
  logic [7:0]         pend_margin, pend_padding;
  logic [COLOR_W-1:0] pend_bg, pend_bcol;
  logic               pend_ben;
  logic [COLOR_W-1:0] pend_color;
  logic [7:0]         pend_size;

  frame_t             stack [STACK_DEPTH];
  logic [SP_W-1:0]    sp;
  logic [GH_W-1:0]    ghost;
  frame_t             top, push_frame;
  logic               stack_full, stack_empty;

  logic fire;
  logic do_char, do_open, do_attr;
  logic do_oend, do_close, text_done;

  logic [IW-1:0]  gw, adv, lh;
  logic           is_space, fits_x, fits_y;
  logic           can_x, char_draw;
  logic [X_W-1:0] wrap_x;
  logic [Y_W-1:0] wrap_y;

  logic [IW-1:0]  lim, auto_w, edge_r;
  logic [X_W-1:0] box_x, box_w, in_left, in_right;
  logic [Y_W-1:0] box_y, box_h, box_bot, in_y;

  assign ev_ready = (state == S_IDLE) ||
                    (state == S_COLLECT);
  assign fire     = ev_valid && ev_ready;

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign top         = stack[IDX_W'(sp - SP_ONE)];

  assign gw  = IW'(size) * IW'(FONT_W);
  assign adv = IW'(size) * IW'(FONT_W + KERN);
  assign lh  = IW'(size) * IW'(FONT_H);

  assign is_space = (ev_value == 8'h20);
  assign fits_x   = (IW'(cur_x) + gw) <= IW'(right);

`ifdef LAYOUT_WRAP_EN
  assign can_x  = 1'b1;
  assign wrap_x = fits_x ? cur_x : left;
  assign wrap_y = fits_x ? cur_y
                         : clamp_y(IW'(cur_y) + lh);
`else
  assign can_x  = fits_x;
  assign wrap_x = cur_x;
  assign wrap_y = cur_y;
`endif

  assign fits_y    = (IW'(wrap_y) + lh) <= IW'(SCREEN_H);
  assign char_draw = !is_space && can_x && fits_y;

  assign box_x  = clamp_x(IW'(left) + IW'(pend_margin));
  assign box_y  = clamp_y(IW'(cur_y) + IW'(pend_margin));
  assign lim    = IW'(left) + (IW'(pend_margin) << 1);
  assign auto_w = (IW'(right) > lim) ? IW'(right) - lim
                                     : '0;
  assign box_w  = clamp_x((pend_width != '0)
                          ? IW'(pend_width) : auto_w);
  assign box_h  = clamp_y(IW'(pend_height));
  assign box_bot = clamp_y(IW'(box_y) + IW'(box_h)
                           + IW'(pend_margin));

  assign in_left  = clamp_x(IW'(box_x) + IW'(pend_padding));
  assign edge_r   = IW'(box_x) + IW'(box_w);
  assign in_right = (edge_r > IW'(pend_padding))
                    ? clamp_x(edge_r - IW'(pend_padding))
                    : '0;
  assign in_y     = clamp_y(IW'(box_y) + IW'(pend_padding));

  assign push_frame = {left, right, color, size, box_bot};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and event decode strobes.
  always_comb begin
    state_next = state;
    do_char    = 1'b0;
    do_open    = 1'b0;
    do_attr    = 1'b0;
    do_oend    = 1'b0;
    do_close   = 1'b0;
    text_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fire) begin
          unique case (1'b1)
            ev_kind == K_CHAR: begin
              do_char = 1'b1;
              if (char_draw) state_next = S_DRAW_TEXT;
            end
            ev_kind == K_OPEN: begin
              do_open    = 1'b1;
              state_next = S_COLLECT;
            end
            ev_kind == K_CLOSE: do_close = 1'b1;
            default: ;
          endcase
        end
      end
      S_COLLECT: begin
        if (fire) begin
          unique case (1'b1)
            ev_kind == K_OPEN: do_open = 1'b1;
            ev_kind == K_ATTR: do_attr = 1'b1;
            ev_kind == K_OEND: begin
              do_oend    = 1'b1;
              state_next = (tag_q == TAG_DIV)
                           ? S_DRAW_RECT : S_IDLE;
            end
            default: ;
          endcase
        end
      end
      S_DRAW_RECT: begin
        if (rect_done) state_next = S_IDLE;
      end
      S_DRAW_TEXT: begin
        if (txt_done) begin
          text_done  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Box stack storage; only the pointer needs a reset.
  always_ff @(posedge clock) begin
    if (!reset && do_oend && tag_q == TAG_DIV
        && !stack_full)
      stack[IDX_W'(sp)] <= push_frame;
  end

  // Frame, cursor, pending attributes and job outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      left              <= '0;
      right             <= X_W'(SCREEN_W);
      color             <= '0;
      size              <= 8'd1;
      cur_x             <= '0;
      cur_y             <= '0;
      tag_q             <= '0;
      pend_width        <= '0;
      pend_height       <= '0;
      pend_margin       <= '0;
      pend_padding      <= '0;
      pend_bg           <= '0;
      pend_bcol         <= '0;
      pend_ben          <= 1'b0;
      pend_color        <= '0;
      pend_size         <= 8'd1;
      sp                <= '0;
      ghost             <= '0;
      err_overflow      <= 1'b0;
      err_underflow     <= 1'b0;
      txt_start         <= 1'b0;
      txt_x             <= '0;
      txt_y             <= '0;
      txt_size          <= 8'd1;
      txt_color         <= '0;
      txt_char          <= '0;
      rect_start        <= 1'b0;
      rect_x            <= '0;
      rect_y            <= '0;
      rect_w            <= '0;
      rect_h            <= '0;
      rect_bg           <= '0;
      rect_border_en    <= 1'b0;
      rect_border_color <= '0;
    end else begin
      txt_start  <= 1'b0;
      rect_start <= 1'b0;

      if (do_open) begin
        tag_q        <= ev_tag;
        pend_width   <= '0;
        pend_height  <= '0;
        pend_margin  <= '0;
        pend_padding <= '0;
        pend_bg      <= '0;
        pend_bcol    <= '0;
        pend_ben     <= 1'b0;
        pend_color   <= color;
        pend_size    <= size;
      end

      if (do_attr) begin
        unique case (1'b1)
          ev_attr == ATT_COLOR:
            pend_color <= ev_value[COLOR_W-1:0];
          ev_attr == ATT_SIZE:    pend_size    <= ev_value;
          ev_attr == ATT_WIDTH:   pend_width   <= ev_value;
          ev_attr == ATT_HEIGHT:  pend_height  <= ev_value;
          ev_attr == ATT_MARGIN:  pend_margin  <= ev_value;
          ev_attr == ATT_PADDING: pend_padding <= ev_value;
          ev_attr == ATT_BG:
            pend_bg <= ev_value[COLOR_W-1:0];
          ev_attr == ATT_BORDER: begin
            pend_bcol <= ev_value[COLOR_W-1:0];
            pend_ben  <= 1'b1;
          end
          default: ;
        endcase
      end

      if (do_oend) begin
        if (tag_q == TAG_DIV) begin
          rect_start        <= 1'b1;
          rect_x            <= box_x;
          rect_y            <= box_y;
          rect_w            <= box_w;
          rect_h            <= box_h;
          rect_bg           <= pend_bg;
          rect_border_en    <= pend_ben;
          rect_border_color <= pend_bcol;
          left              <= in_left;
          right             <= in_right;
          cur_x             <= in_left;
          cur_y             <= in_y;
          if (stack_full) begin
            err_overflow <= 1'b1;
            if (ghost != '1) ghost <= ghost + 1'b1;
          end else begin
            sp <= sp + SP_ONE;
          end
        end else begin
          color <= pend_color;
          size  <= pend_size;
        end
      end

      if (do_close) begin
        if (ev_tag == TAG_DIV) begin
          if (ghost != '0) begin
            ghost <= ghost - 1'b1;
          end else if (stack_empty) begin
            err_underflow <= 1'b1;
          end else begin
            sp    <= sp - SP_ONE;
            left  <= top.left;
            right <= top.right;
            color <= top.color;
            size  <= top.size;
            cur_x <= top.left;
            cur_y <= top.bottom;
          end
        end else begin
          cur_x <= left;
          cur_y <= clamp_y(IW'(cur_y) + lh + IW'(1));
          if (stack_empty) begin
            color <= '0;
            size  <= 8'd1;
          end else begin
            color <= top.color;
            size  <= top.size;
          end
        end
      end

      if (do_char) begin
        if (is_space) begin
          cur_x <= clamp_x(IW'(cur_x) + adv);
        end else begin
          cur_x <= wrap_x;
          cur_y <= wrap_y;
          if (char_draw) begin
            txt_start <= 1'b1;
            txt_x     <= wrap_x;
            txt_y     <= wrap_y;
            txt_size  <= size;
            txt_color <= color;
            txt_char  <= ev_value;
          end
        end
      end

      if (text_done)
        cur_x <= clamp_x(IW'(txt_x) + adv);
    end
  end

endmodule
